// File: rtl/bp_fe_pkg.sv
// Shared types for the FE command ingest endpoint.
//   - FE state enum, command opcode enum, opcode-class enum
//   - bp_fe_cmd_s command packet layout and derived widths
//   - stats counter sizing and the opcode -> class helper
package bp_fe_pkg;

  localparam int vaddr_width_gp    = 39;
  localparam int dword_width_gp    = 64;
  localparam int fe_queue_width_gp = 64;
  localparam int stats_width_gp    = 32;
  localparam int stats_classes_gp  = 4;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_wait  = 2'd1,
    e_run   = 2'd2,
    e_fence = 2'd3
  } bp_fe_cmd_ingest_state_e;

  typedef enum logic [2:0] {
    e_op_state_reset          = 3'd0,
    e_op_pc_redirection       = 3'd1,
    e_op_icache_fill_response = 3'd2,
    e_op_icache_fence         = 3'd3,
    e_op_itlb_fill_response   = 3'd4,
    e_op_wait                 = 3'd5
  } bp_fe_cmd_opcode_e;

  typedef enum logic [1:0] {
    e_cls_redirect = 2'd0,
    e_cls_fence    = 2'd1,
    e_cls_itlb     = 2'd2,
    e_cls_wait     = 2'd3
  } bp_fe_cmd_class_e;

  typedef struct packed {
    bp_fe_cmd_opcode_e           opcode;
    logic [vaddr_width_gp-1:0]   npc;
    logic [dword_width_gp-1:0]   operand;
  } bp_fe_cmd_s;

  localparam int fe_cmd_width_gp = $bits(bp_fe_cmd_s);

  // One-hot class of an accepted opcode; undefined opcodes fall in no class.
  function automatic logic [stats_classes_gp-1:0] opcode_class_mask(input logic [2:0] op);
    logic [stats_classes_gp-1:0] mask;
    mask = '0;
    case (op)
      e_op_state_reset,
      e_op_pc_redirection,
      e_op_icache_fill_response: mask[e_cls_redirect] = 1'b1;
      e_op_icache_fence:         mask[e_cls_fence]    = 1'b1;
      e_op_itlb_fill_response:   mask[e_cls_itlb]     = 1'b1;
      e_op_wait:                 mask[e_cls_wait]     = 1'b1;
      default:                   mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bp_fe_queue_fifo.sv
// Small 1-read 1-write FIFO carrying fetch packets toward the BE.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : empties the FIFO at the end of the cycle (beats a push)
//   data_i, v_i    : push side; v_i must only be raised when ready_o is high
//   ready_o        : not full
//   data_o, v_o    : head entry, valid when not empty (data_o is 0 when empty)
//   yumi_i         : head consumed this cycle
module bp_fe_queue_fifo #(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   rptr_r, wptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               empty, full, push, pop;

  assign empty   = (count_r == '0);
  assign full    = (count_r == cnt_w'(els_p));
  assign ready_o = !full;
  assign v_o     = !empty;
  assign data_o  = empty ? '0 : mem_r[rptr_r];

  assign push = v_i & !full & !clr_i;
  assign pop  = yumi_i & !empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + ptr_w'(1);
      if (pop)  rptr_r <= rptr_r + ptr_w'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_cmd_ingest.sv
// FE-side endpoint of the BE<->FE link: accepts fe_cmd packets, sequences the
// front end through reset/wait/run/fence, drives redirect / fence / ITLB-fill
// requests, and owns the producer side of fe_queue.
// Optional build macro: BP_FE_CMD_INGEST_STATS_EN adds stats_o[127:0]
// (four 32-bit saturating per-class counters: redirect, fence, itlb, wait).
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   fe_cmd_i/_v_i/_yumi_o     command from BE, consumed combinationally
//   redirect_v_o/_pc_o        one-cycle redirect pulse and target
//   fence_v_o, fence_done_i   I$ fence request (level) and completion
//   itlb_fill_v_o/_pte_o      one-cycle ITLB write pulse and pte
//   fetch_en_o                fetch pipeline may issue
//   fetch_pkt_i/_v_i/_ready_and_o   fetch packets into fe_queue
//   fe_queue_o/_v_o/_ready_and_i    fe_queue head toward BE
//   state_o                   current state (bp_fe_cmd_ingest_state_e)
//
// state   | meaning
// e_reset | after reset; only state_reset is accepted
// e_wait  | fetch idle; waits for pc_redirection, services ITLB fills
// e_run   | fetching; every command accepted on arrival
// e_fence | I$ fence outstanding; commands held until fence_done_i
module bp_fe_cmd_ingest
  import bp_fe_pkg::*;
#(
  parameter int fifo_els_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_cmd_width_gp-1:0]   fe_cmd_i,
  input  logic                         fe_cmd_v_i,
  output logic                         fe_cmd_yumi_o,
  output logic                         redirect_v_o,
  output logic [vaddr_width_gp-1:0]    redirect_pc_o,
  output logic                         fence_v_o,
  input  logic                         fence_done_i,
  output logic                         itlb_fill_v_o,
  output logic [dword_width_gp-1:0]    itlb_fill_pte_o,
  output logic                         fetch_en_o,
  input  logic [fe_queue_width_gp-1:0] fetch_pkt_i,
  input  logic                         fetch_v_i,
  output logic                         fetch_ready_and_o,
  output logic [fe_queue_width_gp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_ready_and_i,
  output logic [1:0]                   state_o
`ifdef BP_FE_CMD_INGEST_STATS_EN
  ,
  output logic [stats_classes_gp*stats_width_gp-1:0] stats_o
`endif
);

  localparam logic [1:0] st_reset = e_reset;
  localparam logic [1:0] st_wait  = e_wait;
  localparam logic [1:0] st_run   = e_run;
  localparam logic [1:0] st_fence = e_fence;

  bp_fe_cmd_s                 fe_cmd;
  logic [1:0]                 state_r;
  logic                       redirect_v_r, itlb_fill_v_r, fence_v_r;
  logic [vaddr_width_gp-1:0]  redirect_pc_r, fence_npc_r;
  logic [dword_width_gp-1:0]  itlb_fill_pte_r;
  logic                       fifo_ready;

  assign fe_cmd = bp_fe_cmd_s'(fe_cmd_i);

  always_comb begin
    fe_cmd_yumi_o = 1'b0;
    case (state_r)
      st_reset: fe_cmd_yumi_o = fe_cmd_v_i & (fe_cmd.opcode == e_op_state_reset);
      st_wait:  fe_cmd_yumi_o = fe_cmd_v_i & ((fe_cmd.opcode == e_op_pc_redirection)
                                            | (fe_cmd.opcode == e_op_itlb_fill_response));
      st_run:   fe_cmd_yumi_o = fe_cmd_v_i;
      default:  fe_cmd_yumi_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r         <= st_reset;
      redirect_v_r    <= 1'b0;
      redirect_pc_r   <= '0;
      itlb_fill_v_r   <= 1'b0;
      itlb_fill_pte_r <= '0;
      fence_v_r       <= 1'b0;
      fence_npc_r     <= '0;
    end else begin
      redirect_v_r  <= 1'b0;
      itlb_fill_v_r <= 1'b0;
      case (state_r)
        st_reset: begin
          if (fe_cmd_yumi_o) begin
            redirect_v_r  <= 1'b1;
            redirect_pc_r <= fe_cmd.npc;
            state_r       <= st_wait;
          end
        end
        st_wait: begin
          if (fe_cmd_yumi_o) begin
            if (fe_cmd.opcode == e_op_pc_redirection) begin
              redirect_v_r  <= 1'b1;
              redirect_pc_r <= fe_cmd.npc;
              state_r       <= st_run;
            end else begin
              itlb_fill_v_r   <= 1'b1;
              itlb_fill_pte_r <= fe_cmd.operand;
            end
          end
        end
        st_run: begin
          if (fe_cmd_yumi_o) begin
            case (fe_cmd.opcode)
              e_op_pc_redirection,
              e_op_icache_fill_response: begin
                redirect_v_r  <= 1'b1;
                redirect_pc_r <= fe_cmd.npc;
              end
              e_op_itlb_fill_response: begin
                itlb_fill_v_r   <= 1'b1;
                itlb_fill_pte_r <= fe_cmd.operand;
                redirect_v_r    <= 1'b1;
                redirect_pc_r   <= fe_cmd.npc;
              end
              e_op_icache_fence: begin
                fence_npc_r <= fe_cmd.npc;
                fence_v_r   <= 1'b1;
                state_r     <= st_fence;
              end
              e_op_wait,
              e_op_state_reset: state_r <= st_wait;
              default: ;
            endcase
          end
        end
        st_fence: begin
          if (fence_done_i) begin
            redirect_v_r  <= 1'b1;
            redirect_pc_r <= fence_npc_r;
            fence_v_r     <= 1'b0;
            state_r       <= st_run;
          end
        end
        default: state_r <= st_reset;
      endcase
    end
  end

  assign redirect_v_o    = redirect_v_r;
  assign redirect_pc_o   = redirect_pc_r;
  assign itlb_fill_v_o   = itlb_fill_v_r;
  assign itlb_fill_pte_o = itlb_fill_pte_r;
  assign fence_v_o       = fence_v_r;
  assign fetch_en_o      = (state_r == st_run);
  assign state_o         = state_r;

  // Ready depends only on full, so a push can never meet a full FIFO.
  assign fetch_ready_and_o = fifo_ready & fetch_en_o;

  bp_fe_queue_fifo #(
    .width_p (fe_queue_width_gp),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (fe_cmd_yumi_o),
    .data_i  (fetch_pkt_i),
    .v_i     (fetch_v_i & fetch_ready_and_o),
    .ready_o (fifo_ready),
    .data_o  (fe_queue_o),
    .v_o     (fe_queue_v_o),
    .yumi_i  (fe_queue_ready_and_i)
  );

`ifdef BP_FE_CMD_INGEST_STATS_EN
  logic [stats_classes_gp-1:0] cls_hit;
  assign cls_hit = fe_cmd_yumi_o ? opcode_class_mask(fe_cmd.opcode) : '0;

  for (genvar i = 0; i < stats_classes_gp; i++) begin : g_stat
    logic [stats_width_gp-1:0] cnt_r;
    always_ff @(posedge clk_i) begin
      if (reset_i)                      cnt_r <= '0;
      else if (cls_hit[i] && cnt_r != '1) cnt_r <= cnt_r + stats_width_gp'(1);
    end
    assign stats_o[i*stats_width_gp +: stats_width_gp] = cnt_r;
  end
`endif

endmodule

// File: doc/bp_fe_cmd_ingest.md
Name: bp_fe_cmd_ingest

Overview:
FE-side endpoint of the BE↔FE link. It consumes fe_cmd packets from the BE director on a v/yumi handshake and sequences the front end through reset, run, fence and wait states. It drives redirect, fence and ITLB-fill requests into the fetch pipeline. It also owns the producer side of fe_queue: a small FIFO carries fetch packets toward the BE scheduler, and the FIFO is flushed whenever a command is accepted.

Parameters:
bp_params_p, e_bp_default_cfg, processor configuration; all widths are derived from it (vaddr_width_p, fe_cmd_width_lp, fe_queue_width_lp).
fifo_els_p, 2, fe_queue producer FIFO depth (power of two, ≥2).

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
fe_cmd_i  in  fe_cmd_width_lp  bp_fe_cmd_s from BE
fe_cmd_v_i  in  1  command valid
fe_cmd_yumi_o  out  1  command consumed this cycle
redirect_v_o  out  1  one-cycle PC redirect pulse to fetch
redirect_pc_o  out  vaddr_width_p  redirect target (npc field)
fence_v_o  out  1  I$ fence request, level, held until done
fence_done_i  in  1  I$ fence complete
itlb_fill_v_o  out  1  one-cycle ITLB write pulse
itlb_fill_pte_o  out  dword_width_gp  pte operand from command
fetch_en_o  out  1  fetch pipeline may issue
fetch_pkt_i  in  fe_queue_width_lp  bp_fe_queue_s from fetch
fetch_v_i  in  1  fetch packet valid
fetch_ready_and_o  out  1  FIFO can accept
fe_queue_o  out  fe_queue_width_lp  head packet to BE
fe_queue_v_o  out  1  head valid
fe_queue_ready_and_i  in  1  BE accepts head
state_o  out  2  current FSM state (package enum)

Behaviour:
- States: e_reset(0), e_wait(1), e_run(2), e_fence(3). Reset enters e_reset. Every output resets to 0, and the FIFO is emptied.
- e_reset: fetch_en_o=0. Only state_reset is yumi'd; it pulses redirect to npc and moves to e_wait. Other opcodes are held, with no yumi.
- e_wait: fetch_en_o=0. A pc_redirection is yumi'd, pulses redirect and moves to e_run. An itlb_fill_response is yumi'd and pulses itlb_fill_v_o; state is unchanged.
- e_run: fetch_en_o=1. Every command is yumi'd in the cycle it is valid.
  - pc_redirection or icache_fill_response: redirect pulse.
  - itlb_fill_response: itlb_fill pulse plus redirect.
  - wait: move to e_wait.
  - icache_fence: latch npc, assert fence_v_o, move to e_fence.
  - state_reset: move to e_wait.
- e_fence: fetch_en_o=0, fe_cmd_yumi_o=0 and fence_v_o=1. When fence_done_i arrives, the next cycle pulses redirect to the latched npc, drops fence_v_o and returns to e_run.
- fe_cmd_yumi_o is combinational from fe_cmd_v_i and state. It is never asserted without v.
- redirect_v_o and itlb_fill_v_o are registered, one cycle after yumi.
- FIFO rules:
  - Push = fetch_v_i & fetch_ready_and_o. Pop = fe_queue_v_o & fe_queue_ready_and_i.
  - fetch_ready_and_o = !full & fetch_en_o.
  - Simultaneous push and pop when full is not allowed, because ready depends only on full.
  - Pointers are log2(fifo_els_p) bits with natural wrap. Full/empty are resolved with a count register.
- Flush: any cmd yumi clears the FIFO at the end of that cycle. This takes priority over a same-cycle push, which is dropped, and over a pop (the pop still completes).
- fe_queue_v_o = !empty, and fe_queue_o is the head entry with no bubble.
- Reset mid-fence: fence_v_o drops the next cycle. A fence_done_i arriving in e_reset is ignored.

Optional Feature:
BP_FE_CMD_INGEST_STATS_EN.
- When defined: adds a 32-bit saturating counter per opcode class (redirect, fence, itlb, wait), readable on an extra output stats_o[127:0]. Counters are cleared by reset.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- bp_fe_pkg: bp_fe_cmd_ingest_state_e, the opcode-class enum, and the stats-width localparam.
- The command struct comes from the existing core-interface declare macro.
- One sub-module: bsg_fifo_1r1w_small-style bp_fe_queue_fifo holding the producer FIFO with its clr_i port. The FSM stays in the parent.

Test Plan:
- Reset, then fe_cmd state_reset with npc 0x8000_0000 → yumi in the same cycle. Next cycle redirect_v_o=1 with pc 0x8000_0000 and state e_wait; fetch_en_o stays 0.
- In e_wait, send pc_redirection with npc 0x1000 → state e_run and fetch_en_o=1. Push 2 fetch packets → fetch_ready_and_o=0 when full. Pop order is preserved.
- In e_run with 2 queued packets, send icache_fence with npc 0x2000 → FIFO empty next cycle and fence_v_o=1. A second command is held with yumi=0 for 5 cycles. Assert fence_done_i → redirect to 0x2000 and the second command is then yumi'd.
- Same cycle: command yumi, fetch push and fe_queue pop → pop completes, push dropped, count=0.
- Fence in progress, then assert reset_i → next cycle all outputs are 0 and state is e_reset. A late fence_done_i produces no redirect.
- STATS_EN build: 3 redirects and 1 fence → stats_o redirect field=3 and fence field=1.
